mem_ctrl: RTL
=============

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, meaning the number of cycles the RAM strobe is held, legal range 1..15.
REQ-002 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port clear_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  1  CPU access request.
REQ-005 SHALL have port we  input  1  request type: 1 = write, 0 = read; sampled with req.
REQ-006 SHALL have port cpu_addr  input  9  word address; sampled with req.
REQ-007 SHALL have port wdata  input  32  write data; sampled with req.
REQ-008 SHALL have port rdata  output  32  read data; valid while done=1 after a read.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port err  output  1  high with done when the access was rejected.
REQ-012 SHALL have port read  output  1  RAM read strobe.
REQ-013 SHALL have port write  output  1  RAM write strobe; the RAM is level-sensitive on this strobe.
REQ-014 SHALL have port addr  output  9  RAM address.
REQ-015 SHALL have port data  inout  32  shared RAM data bus.

Function
REQ-016 SHALL implement an FSM with states IDLE, SETUP, ACCESS, HOLD, DONE; all outputs registered.
REQ-017 In IDLE with req=1, SHALL latch we, cpu_addr and wdata, and go to SETUP; req in any other state SHALL be ignored.
REQ-018 If latched cpu_addr[8]=1 (beyond 256 words), SHALL go IDLE->DONE with err=1, never asserting read or write.
REQ-019 addr SHALL hold the latched address from SETUP through DONE.
REQ-020 SETUP SHALL last 1 cycle with read=0 and write=0; for a write, data SHALL be driven with the latched wdata.
REQ-021 ACCESS SHALL last exactly WAIT_CYCLES cycles with read=1 (read) or write=1 (write), using an internal down-counter.
REQ-022 A read SHALL capture data into rdata on the last ACCESS cycle, then go to DONE.
REQ-023 A write SHALL go ACCESS->HOLD (1 cycle, write=0, data still driven), then DONE.
REQ-024 The controller SHALL drive data only in write SETUP/ACCESS/HOLD and SHALL release it to high-Z in all other states; it SHALL never drive while read=1.
REQ-025 read and write SHALL never both be 1.
REQ-026 DONE SHALL last 1 cycle with done=1, then go to IDLE; rdata SHALL hold its value until the next read capture.
REQ-027 Latency from the req-sampling edge to the done assertion SHALL be 2+WAIT_CYCLES cycles for a read and 3+WAIT_CYCLES cycles for a write.
REQ-028 A req high in the DONE cycle SHALL NOT be accepted; it is accepted on the following IDLE cycle.

Reset
REQ-029 clear_n=0 SHALL immediately force IDLE, read=0, write=0, done=0, err=0, busy=0, addr=0, rdata=0, counter=0, and data high-Z, including mid-access.
REQ-030 After clear_n deasserts, the first req SHALL be accepted on the first rising edge in IDLE.

Verification
REQ-031 Read: RAM mem[85]=0x00000002, WAIT_CYCLES=1, req/we=0/addr=85 -> read=1 for 1 cycle; done at +3 cycles; rdata=0x00000002; err=0.
REQ-032 Write then read: write 0x1234ABCD to addr 0x5A -> write=1 for 1 cycle with data stable one cycle before and after; done at +4 cycles; a subsequent read of 0x5A returns 0x1234ABCD.
REQ-033 Out of range: read at addr 0x155 -> done=1, err=1 next state after accept; read and write stay 0 throughout.
REQ-034 WAIT_CYCLES=3 read -> read high exactly 3 cycles; done at +5 cycles.
REQ-035 Reset mid-write: clear_n low during ACCESS -> write=0 and data=Z in the same cycle; RAM content at the address is unchanged if reset precedes the strobe; busy=0.
REQ-036 req held continuously across a read -> exactly one access per IDLE visit; a second access starts the cycle after DONE; no strobe overlap; bus never driven while read=1.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port RAM access controller with a shared data bus.
// Setup, strobed access and write hold phases; every output is a register.
module mem_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        req,
  input  logic        we,
  input  logic [8:0]  cpu_addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        read,
  output logic        write,
  output logic [8:0]  addr,
  inout  tri   [31:0] data
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD,
    DONE
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [8:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      read_q  <= read_d;
      write_q <= write_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = cpu_addr;
          wdata_d = wdata;
          state_d = cpu_addr[8] ? DONE : SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = CNT_INIT;
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (we_q) begin
            state_d = HOLD;
          end else begin
            state_d = DONE;
            rdata_d = data;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs follow the next state so they line up with it
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    err_d   = done_d && addr_d[8];
    read_d  = (state_d == ACCESS) && !we_d;
    write_d = (state_d == ACCESS) && we_d;
    oe_d    = we_d && ((state_d == SETUP) ||
                       (state_d == ACCESS) ||
                       (state_d == HOLD));
  end

  assign rdata = rdata_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;
  assign read  = read_q;
  assign write = write_q;
  assign addr  = addr_q;
  assign data  = oe_q ? wdata_q : 32'bz;

endmodule
